// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice per cycle, LSB first.
// Result and carry are published only when the last bit has been summed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             cy;

    logic s1;
    logic c1;
    logic s;
    logic c2;
    logic carry_next;

    // Full-adder slice built from two half adders and an OR.
    assign s1         = a_sh[0] ^ b_sh[0];
    assign c1         = a_sh[0] & b_sh[0];
    assign s          = s1 ^ cy;
    assign c2         = s1 & cy;
    assign carry_next = c1 | c2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
            cy   <= 1'b0;
            cnt  <= '0;
        end else if (state == ADD) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {s, sum_sh[WIDTH-1:1]};
            cy     <= carry_next;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                sum       <= {s, sum_sh[WIDTH-1:1]};
                carry_out <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16,
// compared against plain integer addition.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit sel16 = 1'b0;
    bit pd8 = 1'b0;
    bit pd16 = 1'b0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .a(a_drv[7:0]), .b(b_drv[7:0]),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16),
        .a(a_drv), .b(b_drv),
        .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // done must be a single-cycle pulse and never overlap busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                check("ovl8", busy8, 0);
                check("pulse8", pd8, 0);
            end
            if (done16) begin
                check("ovl16", busy16, 0);
                check("pulse16", pd16, 0);
            end
        end
        pd8 = done8;
        pd16 = done16;
    end

    function automatic logic cur_busy();
        return sel16 ? busy16 : busy8;
    endfunction

    function automatic logic cur_done();
        return sel16 ? done16 : done8;
    endfunction

    // Called at the first negedge after the accepting edge.
    task automatic wait_done(input logic [15:0] x, input logic [15:0] y, output int dcyc);
        int w;
        int nb;
        bit got;
        int unsigned mask;
        int unsigned full;
        logic [15:0] act_sum;
        logic act_cout;
        w = sel16 ? 16 : 8;
        mask = (1 << w) - 1;
        full = (int'(x) & mask) + (int'(y) & mask);
        nb = 0;
        got = 0;
        dcyc = 0;
        for (int k = 0; k < 60; k++) begin
            if (cur_done()) begin
                got = 1;
                break;
            end
            if (cur_busy()) nb++;
            @(negedge clk);
        end
        check("timeout", got, 1);
        if (got) begin
            dcyc = cyc;
            act_sum = sel16 ? sum16 : {8'h00, sum8};
            act_cout = sel16 ? cout16 : cout8;
            check("sum", act_sum, full & mask);
            check("cout", act_cout, (full >> w) & 1);
            check("busy_n", nb, w);
            check("busy_in_done", cur_busy(), 0);
            @(negedge clk);
            check("done_drop", cur_done(), 0);
        end
    endtask

    task automatic do_op(input bit w16, input logic [15:0] x, input logic [15:0] y);
        int dc;
        sel16 = w16;
        a_drv = x;
        b_drv = y;
        if (w16) start16 = 1'b1;
        else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
        a_drv = 16'($urandom);
        b_drv = 16'($urandom);
        wait_done(x, y, dc);
    endtask

    initial begin
        int c1;
        int c2;
        bit seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        rst = 1'b0;

        do_op(0, 16'h00, 16'h00);
        do_op(0, 16'hA5, 16'h5A);
        do_op(0, 16'hFF, 16'h01);
        do_op(0, 16'hFF, 16'hFF);

        // start held high: operands changed mid-add, re-accepted only in IDLE.
        sel16 = 0;
        @(negedge clk);
        a_drv = 16'h0F;
        b_drv = 16'h01;
        start8 = 1'b1;
        @(negedge clk);
        a_drv = 16'h33;
        b_drv = 16'h44;
        wait_done(16'h0F, 16'h01, c1);
        @(negedge clk);
        wait_done(16'h33, 16'h44, c2);
        start8 = 1'b0;
        check("redone_gap", c2 - c1, 10);

        // Reset in the 4th busy cycle discards the operation.
        @(negedge clk);
        a_drv = 16'h12;
        b_drv = 16'h34;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_sum", sum8, 0);
        check("mid_rst_cout", cout8, 0);
        seen = 0;
        repeat (12) begin
            if (done8) seen = 1;
            @(negedge clk);
        end
        check("mid_rst_nodone", seen, 0);
        do_op(0, 16'h12, 16'h34);

        for (int i = 0; i < 1000; i++) do_op(0, 16'($urandom), 16'($urandom));
        do_op(1, 16'hFFFF, 16'h0001);
        for (int i = 0; i < 1000; i++) do_op(1, 16'($urandom), 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
